mtr_duty_ramp: RTL and testbench
================================

Name: mtr_duty_ramp

Overview:
Slew-rate-limited duty generator that sits directly upstream of the 11-bit PWM stage and drives its duty input. It accepts signed speed commands over a valid/ready handshake and ramps the current speed toward the target by at most STEP per PWM period. It converts the current speed to an offset-binary duty, where 0x400 is zero torque, and updates that duty only at PWM period boundaries. A brake input overrides commands and ramps quickly to zero.

Parameters:
PERIOD_CLKS, 2048, clocks per PWM period; matches the free-running 11-bit PWM counter.
STEP, 16, maximum magnitude change of the current speed per period in normal ramping; legal range 1..511.
BRAKE_MULT, 4, step multiplier applied while braking; BRAKE_MULT*STEP must be ≤ 1023.

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
cmd_vld  in  1  speed command valid
cmd_spd  in  11  signed speed command, two's complement
cmd_rdy  out  1  command accept; transfer occurs when cmd_vld & cmd_rdy
brake  in  1  level brake request
duty  out  11  duty to the PWM stage, registered
duty_upd  out  1  single-cycle pulse in the cycle duty takes a new value
at_target  out  1  current speed equals target and state is not BRAKE

Behaviour:
- Reset and clock: rst_n is the asynchronous, active-low reset; clk is the clock.
- Reset values: prd_cnt=0, tgt=0, cur=0, state=IDLE, duty=11'h400, duty_upd=0. at_target is therefore 1 out of reset. Assertion mid-ramp returns every register to these values immediately.
- Period counter:
  - prd_cnt (11 bits) increments every clk and wraps from PERIOD_CLKS-1 to 0.
  - tick = (prd_cnt == PERIOD_CLKS-1).
  - With the default PERIOD_CLKS, this aligns with the PWM counter, since both reset to 0.
- Handshake:
  - cmd_rdy = ~brake & (state != BRAKE), combinational.
  - On transfer, tgt loads the clipped cmd_spd on the next edge.
  - Clipping: -1024 becomes -1023; all other values pass unchanged, so tgt ∈ [-1023, +1023].
  - A new command may overwrite tgt mid-ramp; the ramp continues from cur toward the new tgt.
- Ramp, evaluated only on tick, using 12-bit signed arithmetic (no wrap):
  - s = STEP, or BRAKE_MULT*STEP in BRAKE.
  - If cur < tgt: cur <= min(cur+s, tgt).
  - If cur > tgt: cur <= max(cur-s, tgt).
  - If cur == tgt: cur holds.
- Simultaneous transfer and tick: the tick uses the old tgt; the new tgt takes effect from the next tick.
- Duty:
  - duty <= 11'h400 + cur[10:0], registered the cycle after cur changes.
  - Latency is tick+2 clks from the tick edge to the new duty; duty range is 0x001..0x7FF.
  - duty_upd pulses in the same cycle duty changes. No pulse when cur is unchanged.
- State machine:
  - IDLE: cur == tgt, no brake. Goes to RAMP on tgt ≠ cur; goes to BRAKE on brake.
  - RAMP: cur ≠ tgt. Goes to IDLE when cur == tgt; goes to BRAKE on brake.
  - BRAKE: entered on the edge brake is sampled high, with tgt forced to 0 on entry. Goes to IDLE when brake == 0 and cur == 0. While brake is still high with cur == 0, it stays in BRAKE and duty holds at 0x400.
- Brake priority: brake wins over a same-cycle cmd_vld. cmd_rdy is already 0 in that cycle, so no transfer occurs.
- at_target = (cur == tgt) & (state != BRAKE), combinational from registers.

Test Plan:
- Basic ramp: reset, then send cmd_spd=160 → cmd_rdy=1 and transfer accepted; duty goes 0x410, 0x420, … 0x4A0 on 10 successive ticks, with one duty_upd per tick and updates spaced exactly 2048 clks apart; at_target=1 after the 10th.
- Partial step: from cur=0, cmd_spd=20 → duty 0x410, then 0x414; holds with no further duty_upd.
- Clip and saturation: cmd_spd=11'h400 (-1024) → tgt=-1023; after 64 ticks duty=0x001 with no wrap.
- Brake: at cur=160, assert brake together with cmd_vld (cmd_spd=300) → cmd_rdy=0 and command not taken; duty 0x460, 0x420, 0x400 over 3 ticks. Hold brake for 2 more ticks → no duty_upd. Release brake → IDLE, at_target=1, cmd_rdy=1.
- Retarget mid-ramp: at cur=64 with tgt=160, send cmd_spd=-32 → next ticks give cur 48, 32, 16, 0, -16, -32; duty ends at 0x3E0.
- Asynchronous reset mid-ramp: drop rst_n between clock edges → duty=0x400, duty_upd=0 and cmd_rdy=1 immediately; first tick after release occurs exactly 2048 clks later.

Source files
------------

// File: rtl/mtr_duty_ramp_if.sv
// Speed-command channel into the duty ramp generator.
//
// Handshake: the master holds cmd_vld high with cmd_spd stable until it
// sees cmd_rdy; a transfer happens on every rising clk edge where
// cmd_vld & cmd_rdy are both high. cmd_rdy may drop without a transfer
// (brake), and cmd_vld may be withdrawn only after a transfer.
//
// Signals:
//   cmd_vld  master -> slave  command valid
//   cmd_spd  master -> slave  signed speed command, 11-bit two's complement
//   cmd_rdy  slave -> master  command accept
interface mtr_duty_ramp_if;
    logic        cmd_vld;
    logic [10:0] cmd_spd;
    logic        cmd_rdy;

    modport master (output cmd_vld, output cmd_spd, input cmd_rdy);
    modport slave  (input cmd_vld, input cmd_spd, output cmd_rdy);
endinterface

// File: rtl/mtr_duty_ramp.sv
// Slew-rate-limited duty generator feeding the 11-bit PWM stage.
//
// Signed speed commands arrive on the cmd channel; the current speed cur
// walks toward the target tgt by at most STEP once per PWM period (at the
// period tick), or BRAKE_MULT*STEP while braking toward zero. The duty
// output is the offset-binary form of cur (0x400 = zero torque) and is
// registered one clock after cur changes, so it only moves at period
// boundaries.
//
// Ports:
//   clk        system clock
//   rst_n      asynchronous active-low reset
//   cmd        speed command channel (slave side)
//   brake      level brake request, overrides commands
//   duty       registered duty to the PWM stage
//   duty_upd   one-cycle pulse in the cycle duty takes a new value
//   at_target  cur == tgt and not braking
//   dbg_state  current FSM state (IDLE=0, RAMP=1, BRAKE=2)
module mtr_duty_ramp #(
    parameter int PERIOD_CLKS = 2048,
    parameter int STEP        = 16,
    parameter int BRAKE_MULT  = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    mtr_duty_ramp_if.slave        cmd,
    input  logic                  brake,
    output logic [10:0]           duty,
    output logic                  duty_upd,
    output logic                  at_target,
    output logic [1:0]            dbg_state
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RAMP  = 2'd1,
        ST_BRAKE = 2'd2
    } state_e;

    localparam logic [10:0]        PRD_LAST  = 11'(PERIOD_CLKS - 1);
    localparam logic signed [11:0] NRM_STEP  = 12'(STEP);
    localparam logic signed [11:0] BRK_STEP  = 12'(BRAKE_MULT * STEP);
    localparam logic [10:0]        DUTY_ZERO = 11'h400;

    state_e             state_q, state_d;
    logic [10:0]        prd_cnt_q, prd_cnt_d;
    logic signed [10:0] tgt_q, tgt_d;
    logic signed [10:0] cur_q, cur_d;
    logic [10:0]        duty_q, duty_d;
    logic               duty_upd_q, duty_upd_d;

    logic               tick;
    logic               cmd_rdy_c;
    logic               xfer;
    logic signed [10:0] cmd_clip;
    logic signed [11:0] cur_x, tgt_x, step, cur_up, cur_dn;

    // Datapath: period counter, target capture, ramp step, duty encode.
    always_comb begin
        tick      = (prd_cnt_q == PRD_LAST);
        prd_cnt_d = tick ? 11'd0 : prd_cnt_q + 11'd1;

        cmd_rdy_c = ~brake & (state_q != ST_BRAKE);
        xfer      = cmd.cmd_vld & cmd_rdy_c;
        // -1024 has no positive mirror; clip so tgt stays symmetric.
        cmd_clip  = (cmd.cmd_spd == 11'h400) ? 11'sh401 : $signed(cmd.cmd_spd);

        tgt_d = tgt_q;
        if (brake && (state_q != ST_BRAKE)) begin
            tgt_d = 11'sd0;
        end else if (xfer) begin
            tgt_d = cmd_clip;
        end

        // 12-bit signed so cur +/- step never wraps before the clamp.
        cur_x  = {cur_q[10], cur_q};
        tgt_x  = {tgt_q[10], tgt_q};
        step   = (state_q == ST_BRAKE) ? BRK_STEP : NRM_STEP;
        cur_up = cur_x + step;
        cur_dn = cur_x - step;

        cur_d = cur_q;
        if (tick) begin
            if (cur_x < tgt_x) begin
                cur_d = (cur_up > tgt_x) ? tgt_q : cur_up[10:0];
            end else if (cur_x > tgt_x) begin
                cur_d = (cur_dn < tgt_x) ? tgt_q : cur_dn[10:0];
            end
        end

        duty_d     = DUTY_ZERO + $unsigned(cur_q);
        duty_upd_d = (duty_d != duty_q);
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (brake) begin
                    state_d = ST_BRAKE;
                end else if (tgt_q != cur_q) begin
                    state_d = ST_RAMP;
                end
            end
            ST_RAMP: begin
                if (brake) begin
                    state_d = ST_BRAKE;
                end else if (cur_q == tgt_q) begin
                    state_d = ST_IDLE;
                end
            end
            ST_BRAKE: begin
                if (!brake && (cur_q == 11'sd0)) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            prd_cnt_q  <= 11'd0;
            tgt_q      <= 11'sd0;
            cur_q      <= 11'sd0;
            duty_q     <= DUTY_ZERO;
            duty_upd_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            prd_cnt_q  <= prd_cnt_d;
            tgt_q      <= tgt_d;
            cur_q      <= cur_d;
            duty_q     <= duty_d;
            duty_upd_q <= duty_upd_d;
        end
    end

    assign cmd.cmd_rdy = cmd_rdy_c;
    assign duty        = duty_q;
    assign duty_upd    = duty_upd_q;
    assign at_target   = (cur_q == tgt_q) && (state_q != ST_BRAKE);
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_mtr_duty_ramp.sv
// Bench for mtr_duty_ramp. The PWM period is shortened to keep run time
// small; everything else uses the default step settings.
module tb_mtr_duty_ramp;

    localparam int P    = 256;
    localparam int STEP = 16;
    localparam int BM   = 4;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        brake = 1'b0;
    logic [10:0] duty;
    logic        duty_upd;
    logic        at_target;
    logic [1:0]  dbg_state;
    logic [1:0]  brk_code = 2'd0;

    int n_vec    = 0;
    int n_err    = 0;
    int edges    = 0;
    int upd_cnt  = 0;
    int last_upd = 0;

    // Behavioural reference: plain integers for speed and target.
    int m_cur = 0;
    int m_tgt = 0;
    bit m_brk = 1'b0;

    mtr_duty_ramp_if cmd_if ();

    mtr_duty_ramp #(
        .PERIOD_CLKS (P),
        .STEP        (STEP),
        .BRAKE_MULT  (BM)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd       (cmd_if),
        .brake     (brake),
        .duty      (duty),
        .duty_upd  (duty_upd),
        .at_target (at_target),
        .dbg_state (dbg_state)
    );

    // ---------------- clock / reset bookkeeping ----------------
    always #5 clk = ~clk;

    // Edges since reset release == expected period counter value.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) edges <= 0;
        else        edges <= edges + 1;
    end

    always @(posedge clk) begin
        if (duty_upd === 1'b1) upd_cnt <= upd_cnt + 1;
    end

    initial begin
        #1500000;
        $display("FAIL watchdog: observed no finish, expected finish before timeout");
        $fatal(1, "timeout");
    end

    // ---------------- helpers ----------------
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int exp_duty(input int c);
        return (1024 + c) & 2047;
    endfunction

    function automatic int clip(input int s);
        return (s == -1024) ? -1023 : s;
    endfunction

    function automatic int ramp(input int c, input int t, input int s);
        if (c < t) return (c + s > t) ? t : c + s;
        if (c > t) return (c - s < t) ? t : c - s;
        return c;
    endfunction

    task automatic check_static(input string tag);
        chk({tag, "/duty"}, duty, exp_duty(m_cur));
        chk({tag, "/rdy"}, cmd_if.cmd_rdy, (!brake && !m_brk));
        chk({tag, "/at_tgt"}, at_target, (m_cur == m_tgt && !m_brk));
    endtask

    task automatic leave_brake(input string tag);
        m_brk = 1'b0;
        chk({tag, "/brk_exit"}, (dbg_state != brk_code), 1);
    endtask

    // Keep single-edge actions off the tick edge.
    task automatic avoid_tick();
        if ((edges % P) == P - 1) @(negedge clk);
    endtask

    // ---------------- driver tasks ----------------
    task automatic send_cmd(input string tag, input int spd);
        bit rdy_exp;
        avoid_tick();
        cmd_if.cmd_vld = 1'b1;
        cmd_if.cmd_spd = 11'(spd);
        rdy_exp = !brake && !m_brk;
        #1;
        chk({tag, "/cmd_rdy"}, cmd_if.cmd_rdy, rdy_exp);
        @(negedge clk);
        cmd_if.cmd_vld = 1'b0;
        if (rdy_exp) m_tgt = clip(spd);
    endtask

    task automatic brake_on(input string tag, input bit with_cmd, input int spd);
        avoid_tick();
        brake = 1'b1;
        if (with_cmd) begin
            cmd_if.cmd_vld = 1'b1;
            cmd_if.cmd_spd = 11'(spd);
        end
        #1;
        chk({tag, "/rdy_low"}, cmd_if.cmd_rdy, 0);
        @(negedge clk);
        cmd_if.cmd_vld = 1'b0;
        m_brk    = 1'b1;
        m_tgt    = 0;
        brk_code = dbg_state;
        check_static(tag);
    endtask

    task automatic brake_off(input string tag);
        avoid_tick();
        brake = 1'b0;
        @(negedge clk);
        if (m_brk && m_cur == 0) leave_brake(tag);
        check_static(tag);
    endtask

    // Runs through one period tick, optionally presenting a command in the
    // same cycle as the tick, and checks duty latency and the update pulse.
    task automatic do_period(input string tag, input bit with_cmd = 1'b0, input int spd = 0);
        int old_cur;
        int u0;
        bit rdy_exp;
        old_cur = m_cur;
        u0      = upd_cnt;
        rdy_exp = 1'b0;
        for (int i = 0; i <= P && (edges % P) != P - 1; i++) @(negedge clk);
        if (with_cmd) begin
            cmd_if.cmd_vld = 1'b1;
            cmd_if.cmd_spd = 11'(spd);
            rdy_exp = !brake && !m_brk;
        end
        m_cur = ramp(m_cur, m_tgt, m_brk ? STEP * BM : STEP);
        @(negedge clk);
        cmd_if.cmd_vld = 1'b0;
        if (rdy_exp) m_tgt = clip(spd);
        chk({tag, "/duty_pre"}, duty, exp_duty(old_cur));
        chk({tag, "/upd_pre"}, duty_upd, 0);
        @(negedge clk);
        if (m_brk && !brake && m_cur == 0) leave_brake(tag);
        chk({tag, "/upd"}, duty_upd, (m_cur != old_cur));
        if (m_cur != old_cur) last_upd = edges;
        check_static(tag);
        @(negedge clk);
        chk({tag, "/upd_cnt"}, upd_cnt - u0, (m_cur != old_cur) ? 1 : 0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int prev_upd;
        int r;
        int s;
        cmd_if.cmd_vld = 1'b0;
        cmd_if.cmd_spd = 11'd0;

        // Reset values
        repeat (2) @(negedge clk);
        chk("rst/duty", duty, 11'h400);
        chk("rst/upd", duty_upd, 0);
        chk("rst/at_tgt", at_target, 1);
        chk("rst/rdy", cmd_if.cmd_rdy, 1);
        rst_n = 1'b1;

        // Basic ramp 0 -> 160, updates one period apart
        send_cmd("basic", 160);
        prev_upd = 0;
        for (int k = 0; k < 10; k++) begin
            do_period("basic");
            if (k > 0) chk("basic/spacing", last_upd - prev_upd, P);
            prev_upd = last_upd;
        end
        chk("basic/final", duty, 11'h4A0);

        // Brake wins over a simultaneous command, fast ramp to zero
        brake_on("brake", 1'b1, 300);
        repeat (3) do_period("brake");
        chk("brake/zero", duty, 11'h400);
        repeat (2) do_period("brake_hold");
        brake_off("brake_rel");

        // Retarget mid-ramp
        send_cmd("retgt", 160);
        repeat (4) do_period("retgt_up");
        send_cmd("retgt", -32);
        repeat (6) do_period("retgt_dn");
        chk("retgt/final", duty, 11'h3E0);

        // Partial final step, then hold
        send_cmd("part", 0);
        repeat (2) do_period("part_zero");
        send_cmd("part", 20);
        repeat (2) do_period("part");
        chk("part/final", duty, 11'h414);
        do_period("part_hold");

        // Command accepted in the tick cycle: tick still uses the old target
        do_period("same_tick", 1'b1, 100);
        do_period("same_next");

        // Clip of -1024 and saturation at 0x001
        send_cmd("clip", 0);
        repeat (3) do_period("clip_zero");
        send_cmd("clip", -1024);
        repeat (64) do_period("clip");
        chk("clip/final", duty, 11'h001);
        do_period("clip_hold");

        // Asynchronous reset between edges, right after a duty update
        send_cmd("arst", 300);
        do_period("arst");
        for (int i = 0; i <= P && (edges % P) != P - 1; i++) @(negedge clk);
        @(posedge clk);
        @(posedge clk);
        #2;
        chk("arst/upd_before", duty_upd, 1);
        rst_n = 1'b0;
        #1;
        chk("arst/duty", duty, 11'h400);
        chk("arst/upd", duty_upd, 0);
        chk("arst/rdy", cmd_if.cmd_rdy, 1);
        chk("arst/at_tgt", at_target, 1);
        m_cur = 0;
        m_tgt = 0;
        m_brk = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        send_cmd("arst_post", 50);
        do_period("arst_post");
        chk("arst/first_tick", last_upd, P + 1);

        // Randomized commands and brakes
        for (int it = 0; it < 8; it++) begin
            repeat ($urandom_range(0, 40)) @(negedge clk);
            r = int'($urandom_range(0, 2047));
            s = (r >= 1024) ? r - 2048 : r;
            send_cmd("rnd", s);
            repeat ($urandom_range(1, 3)) do_period("rnd");
            if ($urandom_range(0, 2) == 0) begin
                brake_on("rnd_brk", 1'($urandom_range(0, 1)), s);
                repeat ($urandom_range(1, 2)) do_period("rnd_brk");
                brake_off("rnd_rel");
                for (int k = 0; k < 20 && m_brk; k++) do_period("rnd_drain");
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
